uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
Byte-level frame parser that sits directly downstream of the UART receive path. It consumes the received-byte strobe and data, and drives the receive-enable back to the receiver. It finds a two-byte header, validates length and checksum, and streams the payload to the application. A per-frame inter-byte timeout recovers the parser from truncated frames.

Parameters:
MAX_LEN, 32, largest legal payload length in bytes (1..255).
TIMEOUT_CLKS, 200000, idle clocks allowed between bytes inside a frame (about 4 byte times at 9600 bps, 50 MHz).

Ports:
CLOCK  in  1  system clock.
RST  in  1  synchronous reset, active-high.
En  in  1  parser enable.
RX_Done_Sig  in  1  one-cycle strobe from the receiver; RX_Data is valid in the same cycle.
RX_Data  in  8  received byte.
RX_En_Sig  out  1  receiver enable; registered copy of En.
Cmd  out  8  command byte of the current or last frame.
Len  out  8  payload length of the current or last frame.
Pay_Data  out  8  payload byte.
Pay_Valid  out  1  one-cycle strobe, Pay_Data valid.
Pay_Idx  out  8  index of Pay_Data within the payload, 0..Len-1.
Frame_Ok  out  1  one-cycle pulse: frame complete, checksum good.
Frame_Err  out  1  one-cycle pulse: frame aborted.
Err_Code  out  2  01 bad length, 10 checksum mismatch, 11 timeout. Valid with Frame_Err, held until the next Frame_Err.
Busy  out  1  high in every state except IDLE.

Behaviour:
- Frame format: 0x55, 0xAA, LEN, CMD, LEN payload bytes, CHK.
- CHK = (LEN + CMD + sum of payload) mod 256.
- All outputs are registered. Every response appears 1 cycle after the RX_Done_Sig cycle that caused it.
- Reset: state IDLE; all outputs 0; internal sum, byte counter and timeout counter cleared. Reset mid-frame discards the frame with no Frame_Err pulse.
- Each cycle with RX_Done_Sig high is one byte. RX_Done_Sig is ignored while En is low.
- States and transitions on a byte:
  - IDLE: 0x55 -> HDR2; any other byte -> stay in IDLE.
  - HDR2: 0xAA -> LEN; 0x55 -> stay in HDR2 (resync); other -> IDLE. No error is raised in HDR2.
  - LEN: byte 0 or byte > MAX_LEN -> Frame_Err, Err_Code=01, go to IDLE. Otherwise Len<=byte, sum<=byte, go to CMD.
  - CMD: Cmd<=byte, sum<=sum+byte (8-bit wrap), payload counter<=0, go to PAY.
  - PAY: Pay_Data<=byte, Pay_Idx<=counter, Pay_Valid pulse, sum+=byte, counter+=1. When counter reaches Len-1 on this byte -> CHK.
  - CHK: byte==sum -> Frame_Ok. Otherwise Frame_Err with Err_Code=10. Go to IDLE either way.
- Payload is streamed before the checksum is known. The consumer must discard buffered payload on Frame_Err.
- Timeout:
  - The counter clears on every accepted byte and counts in all states except IDLE.
  - When the counter reaches TIMEOUT_CLKS with no RX_Done_Sig in that cycle: Frame_Err, Err_Code=11, go to IDLE.
  - A byte arriving in the expiry cycle wins: the byte is processed and the counter clears.
  - The counter saturates and does not wrap.
- En low:
  - State is forced to IDLE on the next edge; sum and counters clear.
  - No Frame_Ok or Frame_Err is emitted; Busy=0.
  - RX_En_Sig follows En with 1-cycle latency.
  - Cmd, Len and Err_Code hold their values.
- Frame_Ok, Frame_Err and Pay_Valid are never high in the same cycle.
- Cmd and Len update as the frame progresses; they are stable from the CMD byte until the next frame's LEN byte.

Test Plan:
- Good frame: bytes 55 AA 03 10 01 02 03 19. Expect Cmd=10, Len=03, Pay_Valid x3 with data 01/02/03 at idx 0/1/2, then a single Frame_Ok, Frame_Err never high.
- Bad checksum: same frame ending 18. Expect 3 payload strobes, then Frame_Err with Err_Code=10, no Frame_Ok.
- Length violation: 55 AA 00, then with MAX_LEN=32, 55 AA 21. Expect Frame_Err Err_Code=01 each time, back to IDLE (Busy=0), no Pay_Valid.
- Resync and garbage: 12 55 55 AA 01 07 09 10. Expect Cmd=07, one payload byte 09, Frame_Ok (sum 01+07+09=11 -> use CHK=11 for pass; CHK=10 -> Err_Code=10).
- Timeout (TIMEOUT_CLKS=100): 55 AA 02 05 then silence. Expect Frame_Err with Err_Code=11 exactly 101 cycles after the last byte's response. Also send a byte exactly at the expiry cycle and confirm no error.
- En drop and reset mid-frame:
  - En low after the CMD byte: no pulses, Busy=0, and RX_En_Sig=0 one cycle later.
  - Re-enable and send a good frame: Frame_Ok.
  - Repeat with RST pulsed instead of En: all outputs 0 after reset.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
// Bus between the UART receive side, the frame parser and the payload consumer.
// The master side drives the enable and the received-byte strobe/data; the
// parser (slave side) returns the receiver enable, frame fields and status.
interface uart_frame_parser_if;
  logic       En;
  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_En_Sig;
  logic [7:0] Cmd;
  logic [7:0] Len;
  logic [7:0] Pay_Data;
  logic       Pay_Valid;
  logic [7:0] Pay_Idx;
  logic       Frame_Ok;
  logic       Frame_Err;
  logic [1:0] Err_Code;
  logic       Busy;

  modport master (
    output En, RX_Done_Sig, RX_Data,
    input  RX_En_Sig, Cmd, Len, Pay_Data, Pay_Valid, Pay_Idx,
    input  Frame_Ok, Frame_Err, Err_Code, Busy
  );

  modport slave (
    input  En, RX_Done_Sig, RX_Data,
    output RX_En_Sig, Cmd, Len, Pay_Data, Pay_Valid, Pay_Idx,
    output Frame_Ok, Frame_Err, Err_Code, Busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Byte-level frame parser: 0x55 0xAA LEN CMD payload[LEN] CHK.
// Payload is streamed as it arrives; the frame is judged on the CHK byte.
// An inter-byte timeout returns the parser to IDLE on truncated frames.
module uart_frame_parser #(
  parameter int MAX_LEN      = 32,
  parameter int TIMEOUT_CLKS = 200000
) (
  input  logic                  CLOCK,
  input  logic                  RST,
  uart_frame_parser_if.slave    bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR2 = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_CMD  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  localparam int          TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]    state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rx_en_q;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    pay_data_q, pay_data_d;
  logic [7:0]    pay_idx_q, pay_idx_d;
  logic          pay_valid_q, pay_valid_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    rx;

  assign rx = bus.RX_Data;

  // Next-state logic: one byte per RX_Done_Sig cycle, timeout when idle mid-frame.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    pay_data_d  = pay_data_q;
    pay_idx_d   = pay_idx_q;
    err_code_d  = err_code_q;
    pay_valid_d = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    if (!bus.En) begin
      // Disabled: drop any frame silently, keep Cmd/Len/Err_Code.
      state_d = S_IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else if (bus.RX_Done_Sig) begin
      // A byte always wins over a timeout expiring in the same cycle.
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx == 8'h55) state_d = S_HDR2;
        end
        S_HDR2: begin
          if (rx == 8'hAA)      state_d = S_LEN;
          else if (rx != 8'h55) state_d = S_IDLE;
        end
        S_LEN: begin
          if (rx == 8'd0 || rx > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
            state_d    = S_IDLE;
          end else begin
            len_d   = rx;
            sum_d   = rx;
            state_d = S_CMD;
          end
        end
        S_CMD: begin
          cmd_d   = rx;
          sum_d   = sum_q + rx;
          cnt_d   = '0;
          state_d = S_PAY;
        end
        S_PAY: begin
          pay_data_d  = rx;
          pay_idx_d   = cnt_q;
          pay_valid_d = 1'b1;
          sum_d       = sum_q + rx;
          cnt_d       = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = S_CHK;
        end
        S_CHK: begin
          if (rx == sum_q) begin
            ok_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // Counter stops at TMO_MAX; reaching it with no byte aborts the frame.
      if (tmo_q == TMO_MAX) begin
        err_d      = 1'b1;
        err_code_d = 2'b11;
        state_d    = S_IDLE;
        sum_d      = '0;
        cnt_d      = '0;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rx_en_q     <= 1'b0;
      cmd_q       <= '0;
      len_q       <= '0;
      pay_data_q  <= '0;
      pay_idx_q   <= '0;
      pay_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rx_en_q     <= bus.En;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      pay_data_q  <= pay_data_d;
      pay_idx_q   <= pay_idx_d;
      pay_valid_q <= pay_valid_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.RX_En_Sig = rx_en_q;
  assign bus.Cmd       = cmd_q;
  assign bus.Len       = len_q;
  assign bus.Pay_Data  = pay_data_q;
  assign bus.Pay_Valid = pay_valid_q;
  assign bus.Pay_Idx   = pay_idx_q;
  assign bus.Frame_Ok  = ok_q;
  assign bus.Frame_Err = err_q;
  assign bus.Err_Code  = err_code_q;
  assign bus.Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected payload/ok/err events are
// queued as bytes are driven and matched against DUT strobes.
module tb_uart_frame_parser;
  localparam int MAXL = 32;
  localparam int TMO  = 100;

  localparam logic [1:0] K_PAY = 2'd0;
  localparam logic [1:0] K_OK  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
    logic [7:0] idx;
    logic [1:0] code;
  } ev_t;

  logic CLOCK;
  logic RST;
  int   total;
  int   bad;
  ev_t  exp_q[$];

  uart_frame_parser_if bus();

  uart_frame_parser #(.MAX_LEN(MAXL), .TIMEOUT_CLKS(TMO)) dut (
    .CLOCK (CLOCK),
    .RST   (RST),
    .bus   (bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] data,
                      input logic [7:0] idx, input logic [1:0] code);
    ev_t e;
    e.kind = kind; e.data = data; e.idx = idx; e.code = code;
    exp_q.push_back(e);
  endtask

  // Assumes we are just after a rising edge; byte is sampled on the next one.
  task automatic pulse(input logic [7:0] b);
    bus.RX_Done_Sig = 1'b1;
    bus.RX_Data     = b;
    @(posedge CLOCK);
    #1;
    bus.RX_Done_Sig = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK);
    #1;
    pulse(b);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge CLOCK);
    #1;
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Match every DUT strobe against the head of the expected-event queue.
  always @(negedge CLOCK) begin
    if (!RST) begin
      if (int'(bus.Pay_Valid) + int'(bus.Frame_Ok) + int'(bus.Frame_Err) > 1)
        chk("excl", 1, 0);
      else if (bus.Pay_Valid || bus.Frame_Ok || bus.Frame_Err) begin
        if (exp_q.size() == 0) begin
          chk("unexp_ev", {bus.Pay_Valid, bus.Frame_Ok, bus.Frame_Err}, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (bus.Pay_Valid) begin
            chk("kind_pay", K_PAY, e.kind);
            chk("pay_data", bus.Pay_Data, e.data);
            chk("pay_idx", bus.Pay_Idx, e.idx);
            $display("ev pay data=%02h idx=%0d", bus.Pay_Data, bus.Pay_Idx);
          end else if (bus.Frame_Ok) begin
            chk("kind_ok", K_OK, e.kind);
            $display("ev frame_ok cmd=%02h len=%02h", bus.Cmd, bus.Len);
          end else begin
            chk("kind_err", K_ERR, e.kind);
            chk("err_code", bus.Err_Code, e.code);
            $display("ev frame_err code=%0d", bus.Err_Code);
          end
        end
      end
    end
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    bus.En = 1'b1;
    bus.RX_Done_Sig = 1'b0;
    bus.RX_Data = 8'h00;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_busy", bus.Busy, 0);
    chk("rst_cmd", bus.Cmd, 0);
    chk("rst_len", bus.Len, 0);
    chk("rst_code", bus.Err_Code, 0);
    chk("rst_rxen", bus.RX_En_Sig, 0);
    RST = 1'b0;
    @(posedge CLOCK);
    #1;
    chk("rxen_on", bus.RX_En_Sig, 1);

    // Good frame
    push(K_PAY, 8'h01, 0, 0); push(K_PAY, 8'h02, 1, 0); push(K_PAY, 8'h03, 2, 0);
    push(K_OK, 0, 0, 0);
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01, 8'h02, 8'h03, 8'h19});
    drain("good_drain");
    chk("good_cmd", bus.Cmd, 8'h10);
    chk("good_len", bus.Len, 8'h03);
    chk("good_busy", bus.Busy, 0);

    // Bad checksum
    push(K_PAY, 8'h01, 0, 0); push(K_PAY, 8'h02, 1, 0); push(K_PAY, 8'h03, 2, 0);
    push(K_ERR, 0, 0, 2'b10);
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01, 8'h02, 8'h03, 8'h18});
    drain("badchk_drain");

    // Length violations: zero and MAX_LEN+1
    push(K_ERR, 0, 0, 2'b01);
    send_seq('{8'h55, 8'hAA, 8'h00});
    drain("len0_drain");
    chk("len0_busy", bus.Busy, 0);
    push(K_ERR, 0, 0, 2'b01);
    send_seq('{8'h55, 8'hAA, 8'h21});
    drain("len33_drain");
    chk("len33_busy", bus.Busy, 0);
    chk("len33_code", bus.Err_Code, 2'b01);

    // Max legal length frame: 32 bytes of 0x01, sum = 20+07+20 = 47
    push(K_OK, 0, 0, 0);
    send_seq('{8'h55, 8'hAA, 8'h20, 8'h07});
    exp_q.delete();
    for (int i = 0; i < 32; i++) push(K_PAY, 8'h01, 8'(i), 0);
    push(K_OK, 0, 0, 0);
    for (int i = 0; i < 32; i++) send_byte(8'h01);
    send_byte(8'h47);
    drain("maxlen_drain");

    // Resync and garbage, pass then fail
    push(K_PAY, 8'h09, 0, 0); push(K_OK, 0, 0, 0);
    send_seq('{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h07, 8'h09, 8'h11});
    drain("resync_drain");
    chk("resync_cmd", bus.Cmd, 8'h07);
    chk("resync_len", bus.Len, 8'h01);
    push(K_PAY, 8'h09, 0, 0); push(K_ERR, 0, 0, 2'b10);
    send_seq('{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h07, 8'h09, 8'h10});
    drain("resync_bad_drain");

    // Timeout: error exactly TMO+1 cycles after the CMD byte's response
    push(K_ERR, 0, 0, 2'b11);
    send_seq('{8'h55, 8'hAA, 8'h02, 8'h05});
    n = 0;
    while (n < 3 * TMO) begin
      @(posedge CLOCK);
      n++;
      #1;
      if (bus.Frame_Err) break;
    end
    chk("tmo_latency", n, TMO + 1);
    chk("tmo_code", bus.Err_Code, 2'b11);
    drain("tmo_drain");
    chk("tmo_busy", bus.Busy, 0);

    // Byte in the expiry cycle wins; frame then completes (02+05+01+02 = 0A)
    push(K_PAY, 8'h01, 0, 0); push(K_PAY, 8'h02, 1, 0); push(K_OK, 0, 0, 0);
    send_seq('{8'h55, 8'hAA, 8'h02, 8'h05});
    repeat (TMO) @(posedge CLOCK);
    #1;
    pulse(8'h01);
    send_byte(8'h02);
    send_byte(8'h0A);
    drain("expiry_drain");

    // En drop after CMD byte
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h10});
    chk("en_busy_pre", bus.Busy, 1);
    bus.En = 1'b0;
    #1;
    chk("en_rxen_lat", bus.RX_En_Sig, 1);
    @(posedge CLOCK);
    #1;
    chk("en_rxen_off", bus.RX_En_Sig, 0);
    chk("en_busy_off", bus.Busy, 0);
    send_seq('{8'h01, 8'h02});
    repeat (TMO + 20) @(posedge CLOCK);
    #1;
    chk("en_cmd_hold", bus.Cmd, 8'h10);
    chk("en_len_hold", bus.Len, 8'h03);
    chk("en_code_hold", bus.Err_Code, 2'b11);
    drain("en_off_drain");
    bus.En = 1'b1;
    push(K_PAY, 8'h01, 0, 0); push(K_PAY, 8'h02, 1, 0); push(K_PAY, 8'h03, 2, 0);
    push(K_OK, 0, 0, 0);
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01, 8'h02, 8'h03, 8'h19});
    drain("en_back_drain");

    // Reset mid-frame
    push(K_PAY, 8'h01, 0, 0);
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01});
    drain("rst_mid_pre");
    @(posedge CLOCK);
    #1;
    RST = 1'b1;
    @(posedge CLOCK);
    #1;
    chk("rstm_busy", bus.Busy, 0);
    chk("rstm_cmd", bus.Cmd, 0);
    chk("rstm_len", bus.Len, 0);
    chk("rstm_pdata", bus.Pay_Data, 0);
    chk("rstm_code", bus.Err_Code, 0);
    chk("rstm_rxen", bus.RX_En_Sig, 0);
    RST = 1'b0;
    push(K_PAY, 8'h01, 0, 0); push(K_PAY, 8'h02, 1, 0); push(K_PAY, 8'h03, 2, 0);
    push(K_OK, 0, 0, 0);
    send_seq('{8'h55, 8'hAA, 8'h03, 8'h10, 8'h01, 8'h02, 8'h03, 8'h19});
    drain("rstm_back_drain");
    chk("rstm_cmd_after", bus.Cmd, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
